// File: rtl/multdiv_seq_pkg.sv
// Shared constants for the iterative multiply/divide unit: widths, ALU opcodes,
// FSM state encoding and iteration counts.
package multdiv_seq_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned MULT_ITERS = WIDTH / 2;
  localparam int unsigned DIV_ITERS  = WIDTH;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADD_W      = WIDTH + 2;
  localparam int unsigned ACC_W      = 2 * WIDTH + 2;

  localparam logic [4:0] MUL_OP = 5'b00110;
  localparam logic [4:0] DIV_OP = 5'b00111;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/cla_full_adder.sv
// Generate/propagate adder with carry-in, shared by the Booth and divide datapaths.
module cla_full_adder #(
  parameter int unsigned W = 34
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum_c = p ^ c[W-1:0];
  end

endmodule

// File: rtl/multdiv_seq_booth_recode.sv
// Radix-4 Booth recoder: maps {b[2i+1], b[2i], b[2i-1]} to a 0 / +-A / +-2A selection.
module booth_recode (
  input  logic [2:0] grp,
  output logic       zero_c,
  output logic       neg_c,
  output logic       two_c
);

  always_comb begin
    zero_c = (grp == 3'b000) || (grp == 3'b111);
    neg_c  = grp[2] && !zero_c;
    two_c  = (grp == 3'b011) || (grp == 3'b100);
  end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (non-restoring) unit.
// Optional MULTDIV_EARLY_ZERO_EN: zero-operand MUL/DIV complete right after the start edge.
module multdiv_seq
  import multdiv_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [WIDTH-1:0]  opnd;
  logic              b_prev;
  logic              sign_diff;
  logic              div_zero;
  logic              div_ovf;
  logic              start_c;
  logic              last_c;
  logic              early_zero_c;
  logic              bz;
  logic              bn;
  logic              b2;
  logic [ADD_W-1:0]  mcand;
  logic [ADD_W-1:0]  add_a;
  logic [ADD_W-1:0]  add_b;
  logic              add_cin;
  logic [ADD_W-1:0]  sum;
  logic [ACC_W-1:0]  mul_nx;
  logic [ACC_W-1:0]  div_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]  quot;
  logic [WIDTH-1:0]  div_res;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;

  assign start_c = ctrl_MULT | ctrl_DIV;
  assign mag_a   = data_operandA[WIDTH-1] ? WIDTH'(-data_operandA) : data_operandA;
  assign mag_b   = data_operandB[WIDTH-1] ? WIDTH'(-data_operandB) : data_operandB;

`ifdef MULTDIV_EARLY_ZERO_EN
  // Divide-by-zero is deliberately excluded so it keeps the full latency.
  assign early_zero_c = ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                                  : ((data_operandA == '0) && (data_operandB != '0));
`else
  assign early_zero_c = 1'b0;
`endif

  booth_recode u_booth (
    .grp    ({acc[1:0], b_prev}),
    .zero_c (bz),
    .neg_c  (bn),
    .two_c  (b2)
  );

  // MUL: acc = {hi[33:0], multiplier}; DIV: acc[64:32] = remainder, acc[31:0] = quotient.
  always_comb begin
    mcand = b2 ? {opnd[WIDTH-1], opnd, 1'b0} : {{2{opnd[WIDTH-1]}}, opnd};
    if (bz) begin
      mcand = '0;
    end
    if (state == ST_DIV) begin
      add_a   = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      add_b   = acc[2*WIDTH] ? {2'b00, opnd} : ~{2'b00, opnd};
      add_cin = ~acc[2*WIDTH];
    end else begin
      add_a   = acc[ACC_W-1:WIDTH];
      add_b   = bn ? ~mcand : mcand;
      add_cin = bn;
    end
  end

  cla_full_adder #(.W(ADD_W)) u_add (
    .a     (add_a),
    .b     (add_b),
    .cin   (add_cin),
    .sum_c (sum)
  );

  assign mul_nx  = {{2{sum[ADD_W-1]}}, sum, acc[WIDTH-1:2]};
  assign div_nx  = {sum, acc[WIDTH-2:0], ~sum[WIDTH]};
  assign prod    = mul_nx[2*WIDTH-1:0];
  assign quot    = div_nx[WIDTH-1:0];
  assign div_res = sign_diff ? WIDTH'(-quot) : quot;

  // Next state; a start edge overrides whatever is in flight.
  always_comb begin
    state_nx = state;
    last_c   = 1'b0;
    if (start_c) begin
      state_nx = early_zero_c ? ST_DONE : (ctrl_MULT ? ST_MUL : ST_DIV);
    end else begin
      case (state)
        ST_MUL: if (cnt == CNT_W'(MULT_ITERS - 1)) begin
          last_c   = 1'b1;
          state_nx = ST_DONE;
        end
        ST_DIV: if (cnt == CNT_W'(DIV_ITERS - 1)) begin
          last_c   = 1'b1;
          state_nx = ST_DONE;
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      acc            <= '0;
      opnd           <= '0;
      b_prev         <= 1'b0;
      sign_diff      <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy           <= (state_nx != ST_IDLE);
      data_resultRDY <= (state_nx == ST_DONE);
      if (start_c) begin
        cnt            <= '0;
        b_prev         <= 1'b0;
        data_result    <= '0;
        data_exception <= 1'b0;
        sign_diff      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero       <= (data_operandB == '0);
        div_ovf        <= (data_operandA == INT_MIN) && (data_operandB == '1);
        if (ctrl_MULT) begin
          opnd <= data_operandA;
          acc  <= {ADD_W'(0), data_operandB};
        end else begin
          opnd <= mag_b;
          acc  <= {ADD_W'(0), mag_a};
        end
      end else if (state == ST_MUL) begin
        cnt    <= cnt + CNT_W'(1);
        acc    <= mul_nx;
        b_prev <= acc[1];
        if (last_c) begin
          data_result    <= prod[WIDTH-1:0];
          data_exception <= (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        end
      end else if (state == ST_DIV) begin
        cnt <= cnt + CNT_W'(1);
        acc <= div_nx;
        if (last_c) begin
          data_result    <= div_zero ? '0 : div_res;
          data_exception <= div_zero | div_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq: latency, results, exceptions, abort and reset.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse a start, wait (bounded) for RDY, then check latency, busy, result and the following cycle.
  task automatic run_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc, input int exp_lat,
                        input string tag);
    int   n;
    logic busy_ok;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mul;
    ctrl_DIV      = ~is_mul;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    n         = 0;
    busy_ok   = 1'b1;
    while (data_resultRDY !== 1'b1 && n < 64) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_res"}, data_result, exp_res);
    chk({tag, "_exc"}, {31'b0, data_exception}, {31'b0, exp_exc});
    @(posedge clock); #1;
    chk({tag, "_rdy_pulse"}, {31'b0, data_resultRDY}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_hold"}, data_result, exp_res);
  endtask

  initial begin
    logic rdy_seen;
    reset         = 1'b1;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", {31'b0, data_exception}, 32'd0);
    chk("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Multiply
    run_op(1'b1, 32'd6,          32'd7,          32'd42,         1'b0, 16, "mul_6x7");
    run_op(1'b1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1'b0, 16, "mul_m3x5");
    run_op(1'b1, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 16, "mul_ovf");
    run_op(1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 16, "mul_m1xm1");
    run_op(1'b1, 32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1, 16, "mul_max2");
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 16, "mul_minxm1");

    // Divide
    run_op(1'b0, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0, 32, "div_100_m7");
    run_op(1'b0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, 32, "div_m100_7");
    run_op(1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 32, "div_7_m2");
    run_op(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 32, "div_m1_m1");
    run_op(1'b0, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 32, "div_min_1");
    run_op(1'b0, 32'd5,          32'd0,          32'd0,          1'b1, 32, "div_by0");
    run_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 32, "div_min_m1");

    // Abort: MUL 9x9 restarted by DIV 50/5 eight cycles later
    @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT     = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    rdy_seen  = 1'b0;
    repeat (7) begin
      if (data_resultRDY !== 1'b0) rdy_seen = 1'b1;
      @(posedge clock); #1;
    end
    chk("abort_no_early_rdy", {31'b0, rdy_seen}, 32'd0);
    run_op(1'b0, 32'd50, 32'd5, 32'd10, 1'b0, 32, "abort_div");

    // Asynchronous reset ten cycles into a divide
    @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_rdy", {31'b0, data_resultRDY}, 32'd0);
    chk("arst_result", data_result, 32'd0);
    chk("arst_exc", {31'b0, data_exception}, 32'd0);
    @(negedge clock);
    reset    = 1'b0;
    rdy_seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) rdy_seen = 1'b1;
    end
    chk("arst_no_rdy", {31'b0, rdy_seen}, 32'd0);

    // Zero operands
`ifdef MULTDIV_EARLY_ZERO_EN
    run_op(1'b1, 32'd0, 32'd123, 32'd0, 1'b0, 0,  "mul_zero");
    run_op(1'b0, 32'd0, 32'd5,   32'd0, 1'b0, 0,  "div_zero_num");
`else
    run_op(1'b1, 32'd0, 32'd123, 32'd0, 1'b0, 16, "mul_zero");
    run_op(1'b0, 32'd0, 32'd5,   32'd0, 1'b0, 32, "div_zero_num");
`endif
    run_op(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 32, "div_0_by0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Iterative signed 32-bit multiply/divide unit used by the execute stage for R-type mul (ALU op 00110) and div (ALU op 00111).
- X stage pulses a start control. The unit latches operands and iterates.
- It returns the result with a one-cycle ready pulse. The hazard logic stalls F/D/X while busy is high.
- Multiply uses radix-4 Booth. Divide uses non-restoring division with sign fix-up.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- MULT_ITERS, 16, Booth radix-4 iterations (WIDTH/2).
- DIV_ITERS, 32, division iterations (WIDTH).

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_operandA  in  32  multiplicand / dividend; sampled only at a start edge.
- data_operandB  in  32  multiplier / divisor; sampled only at a start edge.
- ctrl_MULT  in  1  one-cycle start pulse for multiply.
- ctrl_DIV  in  1  one-cycle start pulse for divide.
- data_result  out  32  low 32 bits of product, or quotient.
- data_exception  out  1  overflow / divide-by-zero flag, valid with ready.
- data_resultRDY  out  1  single-cycle pulse: result and exception valid.
- busy  out  1  high from the cycle after a start edge through the RDY cycle.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; counter = 0.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
  - Reset mid-operation abandons the operation; no RDY is ever produced for it.
- States: IDLE, MUL, DIV, DONE.
- Start edge E0 (ctrl_MULT or ctrl_DIV high at a rising edge):
  - Latch operands; clear the 64-bit accumulator / remainder; counter = 0.
  - Enter MUL or DIV. This applies from any state.
- Simultaneous ctrl_MULT and ctrl_DIV: MULT wins.
- A start while busy aborts the current operation and restarts with the new operands. No RDY is produced for the aborted operation.
- MUL:
  - Edges E1..E16 each perform one Booth step on multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0.
  - Step operations: add 0, ±A, or ±2A to the upper partial product, then arithmetic shift right by 2.
  - At E16 go to DONE.
- DIV:
  - Operate on operand magnitudes. Edges E1..E32 each perform one non-restoring step (shift, add/sub divisor, set quotient bit).
  - At E32 apply the final remainder correction (remainder discarded). Negate the quotient if the operand signs differ; truncate toward zero.
  - Go to DONE.
- DONE:
  - Entered at E16 (MUL) or E32 (DIV). data_resultRDY = 1 for exactly the cycle between that edge and the next one.
  - Then return to IDLE.
  - data_result and data_exception hold their values until the next start edge, where both clear to 0.
- Latency: RDY is visible 16 cycles after the MUL start edge and 32 cycles after the DIV start edge.
- Exceptions:
  - MUL: set if the 64-bit product is not the sign extension of its low 32 bits. Result = low 32 bits.
  - DIV by zero: result = 0, exception = 1, full 32-cycle latency.
  - DIV 0x80000000 / 0xFFFFFFFF: result = 0x80000000, exception = 1.
- Start pulse held for more than one cycle: each high edge restarts the operation. Callers must pulse.

Optional Feature:
- Macro: MULTDIV_EARLY_ZERO_EN.
- Defined:
  - MUL with A == 0 or B == 0, or DIV with A == 0 and B != 0, skips iteration.
  - E0 goes directly to DONE; RDY is visible in the cycle after E0; result = 0, exception = 0.
  - Divide-by-zero still takes 32 cycles.
- Undefined: fixed latencies as above for all operands.

Decomposition:
- Shared package:
  - ALU opcode constants MUL_OP = 5'b00110, DIV_OP = 5'b00111.
  - State encoding (IDLE/MUL/DIV/DONE).
  - MULT_ITERS and DIV_ITERS constants.
  - INT_MIN constant.
- Sub-modules:
  - booth_recode: 3-bit group in, outputs {zero, neg, two}. This is the one natural sub-module.
  - The add/sub datapath instantiates the existing cla_full_adder; no new adder.

Test Plan:
- MUL 6 × 7 -> RDY exactly 16 cycles after start, result 42, exception 0; busy high during those 16 cycles.
- MUL −3 (0xFFFFFFFD) × 5 -> 0xFFFFFFF1; then MUL 0x00010000 × 0x00010000 -> result 0, exception 1.
- DIV 100 / −7 -> 0xFFFFFFF2 (−14); −100 / 7 -> −14; RDY 32 cycles after start.
- DIV 5 / 0 -> result 0, exception 1 at cycle 32; DIV 0x80000000 / −1 -> 0x80000000, exception 1.
- Start MUL 9 × 9, then ctrl_DIV 50 / 5 at cycle 8 -> no RDY for the MUL; a single RDY 32 cycles after the DIV start, result 10.
- Assert reset at cycle 10 of a DIV -> all outputs 0 immediately (asynchronous); no RDY afterwards. With MULTDIV_EARLY_ZERO_EN, MUL 0 × 123 -> RDY in the cycle after start, result 0.
